// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core memories.
//   instr_t       : one 32-bit instruction word
//   NOP_INSTR     : the all-zero sll $0,$0,0 encoding used as the fill value
//   imem_state_e  : controller states of the loadable instruction memory
//   is_misaligned : true when a byte address is not word aligned
package mips_pkg;

  typedef logic [31:0] instr_t;

  localparam instr_t NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } imem_state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_lsbs);
    return byte_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Fetch and program-load port bundle of the instruction memory.
//   fetch_* : byte-addressed instruction fetch, one-cycle registered response
//   load_*  : word-stream program load (valid/ready, load_last ends the burst)
//   busy    : memory is clearing or loading and cannot serve fetches
// Modports: master = core / boot loader side, slave = memory side.
interface instr_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 32
) ();

  localparam int IDX_W = $clog2(DEPTH);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_misalign;
  logic              fetch_oor;

  logic              load_start;
  logic [IDX_W-1:0]  load_base;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;

  logic              busy;

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_ready, fetch_valid, fetch_instr, fetch_misalign, fetch_oor,
    output load_start, load_base, load_valid, load_data, load_last,
    input  load_ready, load_done,
    input  busy
  );

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_ready, fetch_valid, fetch_instr, fetch_misalign, fetch_oor,
    input  load_start, load_base, load_valid, load_data, load_last,
    output load_ready, load_done,
    output busy
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W single-port storage for the instruction memory.
// One shared address; a write takes priority in the controller's address mux.
// The read data register only updates when i_re is high, so it holds the
// last fetched word between fetches.
//   clk     : rising-edge clock
//   i_we    : write enable, writes i_wdata to mem[i_addr]
//   i_re    : read enable, captures mem[i_addr] into o_rdata
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array and its read register are deliberately left out of reset
  // so the storage maps onto a RAM macro; the controller's clear sweep
  // initialises the contents and masks r_rdata until the first good read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory controller for the MIPS core.
// After reset a CLEAR sweep writes NOP_WORD to every word (DEPTH cycles),
// then IDLE serves fetches with a one-cycle registered response and flags
// misaligned or out-of-range addresses. load_start moves to LOAD, where a
// valid/ready word stream is written from load_base upwards (wrapping modulo
// DEPTH) until a beat carrying load_last.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch / load / busy bundle (instr_mem_ctrl_if.slave)
module instr_mem_ctrl
  import mips_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_ctrl_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  imem_state_e       r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic              r_fetch_valid;
  logic              r_misalign;
  logic              r_oor;
  logic              r_use_mem;
  logic [DATA_W-1:0] r_fault_instr;
  logic              r_load_done;

  logic              w_fetch_acc;
  logic              w_misalign;
  logic              w_oor;
  logic [IDX_W-1:0]  w_fetch_idx;
  logic              w_load_beat;
  logic              w_we;
  logic              w_re;
  logic [IDX_W-1:0]  w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // Fetch decode. The range check uses the whole word address, so high
  // address bits that the truncated index would drop still raise the fault.
  assign w_fetch_acc = bus.fetch_req && (r_state == IDLE);
  assign w_misalign  = is_misaligned(bus.fetch_addr[1:0]);
  assign w_oor       = {2'b00, bus.fetch_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH);
  assign w_fetch_idx = bus.fetch_addr[IDX_W+1:2];

  // Writes happen only in CLEAR and LOAD, reads only in IDLE, so one port
  // suffices and the address mux never sees both at once.
  assign w_load_beat = (r_state == LOAD) && bus.load_valid;
  assign w_we        = (r_state == CLEAR) || w_load_beat;
  assign w_re        = w_fetch_acc && !w_misalign && !w_oor;
  assign w_addr      = w_we ? r_ptr : w_fetch_idx;
  assign w_wdata     = (r_state == CLEAR) ? NOP_WORD : bus.load_data;

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every register samples pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= CLEAR;
      r_ptr         <= '0;
      r_fetch_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_oor         <= 1'b0;
      r_use_mem     <= 1'b0;
      r_fault_instr <= '0;
      r_load_done   <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_load_done   <= 1'b0;

      // Response fields only change on an accepted fetch, so they hold
      // between responses.
      if (w_fetch_acc) begin
        r_fetch_valid <= 1'b1;
        r_misalign    <= w_misalign;
        r_oor         <= w_oor;
        r_use_mem     <= !(w_misalign || w_oor);
        if (w_misalign || w_oor) begin
          r_fault_instr <= NOP_WORD;
        end
      end

      case (r_state)
        CLEAR: begin
          r_ptr <= r_ptr + IDX_W'(1);
          if (r_ptr == LAST_IDX) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (bus.load_start) begin
            r_ptr   <= bus.load_base;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            // Power-of-two depth: the natural overflow is the modulo wrap.
            r_ptr <= r_ptr + IDX_W'(1);
            if (bus.load_last) begin
              r_state     <= IDLE;
              r_load_done <= 1'b1;
            end
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Good reads come straight from the array's read register; faulted reads
  // (and the post-reset state) come from r_fault_instr.
  assign bus.fetch_instr    = r_use_mem ? w_rdata : r_fault_instr;
  assign bus.fetch_valid    = r_fetch_valid;
  assign bus.fetch_misalign = r_misalign;
  assign bus.fetch_oor      = r_oor;
  assign bus.fetch_ready    = (r_state == IDLE);
  assign bus.load_ready     = (r_state == LOAD);
  assign bus.load_done      = r_load_done;
  assign bus.busy           = (r_state != IDLE);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: directed steps plus randomized
// loads/fetches, checked against a plain array model of the memory.
module tb_instr_mem_ctrl;

  localparam int          DEPTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) bus ();

  instr_mem_ctrl #(
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .NOP_WORD (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_mis(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic exp_oor(input logic [31:0] a);
    return (a / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    if (exp_mis(a) || exp_oor(a)) return NOP;
    return model[int'(a / 4)];
  endfunction

  task automatic idle_inputs();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
  endtask

  task automatic check_resp(input logic [31:0] a, input string tag);
    check($sformatf("%s_valid@%h", tag, a), {31'b0, bus.fetch_valid}, 32'd1);
    check($sformatf("%s_instr@%h", tag, a), bus.fetch_instr, exp_instr(a));
    check($sformatf("%s_mis@%h", tag, a), {31'b0, bus.fetch_misalign}, {31'b0, exp_mis(a)});
    check($sformatf("%s_oor@%h", tag, a), {31'b0, bus.fetch_oor}, {31'b0, exp_oor(a)});
  endtask

  // Issues the addresses on consecutive cycles, then checks the last
  // response holds while fetch_valid drops.
  task automatic fetch_seq(input logic [31:0] addrs[$], input string tag);
    logic [31:0] last_a;
    last_a = '0;
    foreach (addrs[i]) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = addrs[i];
      tick();
      check_resp(addrs[i], tag);
      last_a = addrs[i];
    end
    bus.fetch_req = 1'b0;
    tick();
    check({tag, "_valid_drop"}, {31'b0, bus.fetch_valid}, 32'd0);
    check({tag, "_hold"}, bus.fetch_instr, exp_instr(last_a));
  endtask

  // Counts cycles until busy falls; optionally drives ignored requests.
  task automatic wait_clear(input bit noise, input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (noise) begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0;
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_data  = 32'hBAD0_BAD0;
      end
      tick();
      n++;
      if (noise) check({tag, "_no_resp"}, {31'b0, bus.fetch_valid}, 32'd0);
    end
    idle_inputs();
    check({tag, "_clear_len"}, n, DEPTH);
    check({tag, "_fetch_ready"}, {31'b0, bus.fetch_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
  endtask

  task automatic start_load(input int base, input string tag);
    bus.load_start = 1'b1;
    bus.load_base  = 5'(base);
    tick();
    bus.load_start = 1'b0;
    check({tag, "_load_ready"}, {31'b0, bus.load_ready}, 32'd1);
    check({tag, "_fetch_ready0"}, {31'b0, bus.fetch_ready}, 32'd0);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
  endtask

  // Sends words, the last one with load_last. With bubbles set, idle cycles
  // carry noise (stray load_last, load_start, fetch_req) that must be ignored.
  task automatic send_beats(input int base, input logic [31:0] words[$],
                            input bit bubbles, input string tag);
    foreach (words[i]) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        bus.load_valid = 1'b0;
        bus.load_last  = 1'($urandom_range(0, 1));
        bus.load_start = 1'($urandom_range(0, 1));
        bus.load_base  = 5'($urandom_range(0, DEPTH - 1));
        bus.fetch_req  = 1'($urandom_range(0, 1));
        bus.fetch_addr = 32'($urandom_range(0, 127)) << 2;
        tick();
        check({tag, "_bubble_ready"}, {31'b0, bus.load_ready}, 32'd1);
        check({tag, "_bubble_nofetch"}, {31'b0, bus.fetch_valid}, 32'd0);
      end
      bus.load_start = bubbles ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.fetch_req  = bubbles ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      bus.load_last  = (i == words.size() - 1);
      tick();
      model[(base + i) % DEPTH] = words[i];
      check({tag, "_beat_nofetch"}, {31'b0, bus.fetch_valid}, 32'd0);
      if (i == words.size() - 1) begin
        check({tag, "_done"}, {31'b0, bus.load_done}, 32'd1);
        check({tag, "_idle"}, {31'b0, bus.fetch_ready}, 32'd1);
      end else begin
        check({tag, "_not_done"}, {31'b0, bus.load_done}, 32'd0);
      end
    end
    idle_inputs();
    tick();
    check({tag, "_done_pulse"}, {31'b0, bus.load_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] old0;
    int          base;
    int          len;

    idle_inputs();
    #2;
    check("rst_busy", {31'b0, bus.busy}, 32'd1);
    check("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    check("rst_fetch_instr", bus.fetch_instr, 32'd0);
    check("rst_flags", {30'b0, bus.fetch_misalign, bus.fetch_oor}, 32'd0);
    check("rst_ready", {30'b0, bus.fetch_ready, bus.load_ready}, 32'd0);
    check("rst_load_done", {31'b0, bus.load_done}, 32'd0);
    #10 rst_n = 1'b1;

    wait_clear(1'b0, "boot");
    q = {}; q.push_back(32'h7C);
    fetch_seq(q, "first");

    // Three-word program at index 0, then back-to-back fetches.
    start_load(0, "prog");
    q = {}; q.push_back(32'h2008_0014); q.push_back(32'h2009_000F); q.push_back(32'h0128_802A);
    send_beats(0, q, 1'b0, "prog");
    q = {}; q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8);
    fetch_seq(q, "b2b");

    // Faults, including a high address bit the truncated index would hide.
    q = {}; q.push_back(32'h6); q.push_back(32'h80); q.push_back(32'h82);
    q.push_back(32'h8000_0000); q.push_back(32'hFFFF_FFFC); q.push_back(32'h4);
    fetch_seq(q, "fault");

    // Wrap from base 30.
    start_load(30, "wrap");
    q = {}; q.push_back(32'hAAAA_0001); q.push_back(32'hBBBB_0002); q.push_back(32'hCCCC_0003);
    send_beats(30, q, 1'b0, "wrap");
    q = {}; q.push_back(32'h78); q.push_back(32'h7C); q.push_back(32'h0); q.push_back(32'h4);
    fetch_seq(q, "wrapf");

    // Randomized loads (some longer than DEPTH) with noisy bubbles.
    for (int r = 0; r < 4; r++) begin
      base = $urandom_range(0, DEPTH - 1);
      len  = (r == 3) ? DEPTH + 7 : $urandom_range(1, 12);
      start_load(base, "rnd");
      q = {};
      for (int k = 0; k < len; k++) q.push_back($urandom);
      send_beats(base, q, 1'b1, "rnd");
      q = {};
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 3) != 0) q.push_back(32'($urandom_range(0, DEPTH - 1)) << 2);
        else q.push_back(32'($urandom_range(0, 255)));
      end
      fetch_seq(q, "rndf");
    end

    // load_start and fetch in the same IDLE cycle.
    old0 = model[0];
    bus.load_start = 1'b1;
    bus.load_base  = 5'd0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0;
    tick();
    idle_inputs();
    check("simul_valid", {31'b0, bus.fetch_valid}, 32'd1);
    check("simul_old", bus.fetch_instr, old0);
    check("simul_load", {31'b0, bus.load_ready}, 32'd1);
    q = {}; q.push_back(32'hDEAD_BEEF);
    send_beats(0, q, 1'b0, "simul");
    q = {}; q.push_back(32'h0);
    fetch_seq(q, "simulf");

    // Asynchronous reset in the middle of a load.
    start_load(0, "rstmid");
    for (int k = 0; k < 2; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 32'h1234_0000 + 32'(k);
      bus.load_last  = 1'b0;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("rstmid_instr", bus.fetch_instr, 32'd0);
    check("rstmid_busy", {31'b0, bus.busy}, 32'd1);
    check("rstmid_ready", {30'b0, bus.fetch_ready, bus.load_ready}, 32'd0);
    check("rstmid_pulses", {30'b0, bus.fetch_valid, bus.load_done}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(1'b1, "rstmid");
    q = {}; q.push_back(32'h0); q.push_back(32'h4);
    fetch_seq(q, "rstmidf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised, loadable instruction memory for the MIPS core, replacing the fixed-content ROM.
- After reset, a clear sweep fills every word with NOP_WORD.
- Serves byte-addressed fetches with a registered one-cycle read and fault reporting.
- Accepts a word-stream program load from a testbench or boot loader through a valid/ready port.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 32, number of words; must be a power of two and at least 2.
- ADDR_W, 32, width of the byte address on the fetch port.
- NOP_WORD, 32'h0000_0000, fill value and faulted-read value.
- IDX_W (localparam), $clog2(DEPTH), word index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request; accepted when fetch_ready=1.
- fetch_addr  in  ADDR_W  byte address of the fetch.
- fetch_ready  out  1  high only in IDLE.
- fetch_valid  out  1  one-cycle pulse: response is valid.
- fetch_instr  out  DATA_W  fetched word.
- fetch_misalign  out  1  response fault: fetch_addr[1:0] != 0.
- fetch_oor  out  1  response fault: word index >= DEPTH.
- load_start  in  1  enter LOAD; sampled only in IDLE.
- load_base  in  IDX_W  first word index written by the load.
- load_valid  in  1  load word present.
- load_data  in  DATA_W  load word.
- load_last  in  1  marks the final word of the load.
- load_ready  out  1  high only in LOAD.
- load_done  out  1  one-cycle pulse after the last word is written.
- busy  out  1  high in CLEAR or LOAD.

Behaviour:
- Reset (async assert, sync release):
  - state=CLEAR, clear pointer=0.
  - All outputs 0: fetch_instr=0 and every flag/pulse low.
  - busy=1 is driven combinationally from CLEAR.
- Reset mid-operation: any fetch or load in flight is abandoned, no response is produced, and the sweep restarts from index 0.
- CLEAR state:
  - Writes NOP_WORD to mem[ptr] each cycle, then ptr++.
  - After writing DEPTH-1, goes to IDLE, so CLEAR lasts exactly DEPTH cycles.
  - fetch_req, load_start and load_valid are ignored.
- IDLE state:
  - fetch_ready=1.
  - Fetch accepted on (fetch_req && fetch_ready) at edge N. At edge N+1, fetch_valid=1 for one cycle.
  - Index = fetch_addr >> 2, using the full ADDR_W width for the range check.
  - Misaligned (addr[1:0]!=0): fetch_misalign=1, fetch_instr=NOP_WORD.
  - Out of range (index >= DEPTH): fetch_oor=1, fetch_instr=NOP_WORD.
  - Both faults may assert together.
  - No fault: fetch_instr=mem[index], both flags 0.
  - fetch_instr and the flags hold their values until the next response. fetch_valid drops after one cycle.
  - Back-to-back fetches: one accepted per cycle, throughput 1.
- Entering LOAD:
  - load_start in IDLE: ptr=load_base, next state LOAD.
  - If fetch_req arrives in the same cycle, the fetch is also accepted and returns pre-load contents.
- LOAD state:
  - load_ready=1, fetch_ready=0, busy=1.
  - Each (load_valid && load_ready) edge writes mem[ptr]=load_data, then ptr++ modulo DEPTH (wraps DEPTH-1 -> 0).
  - A beat with load_last=1 writes its word, then goes to IDLE and pulses load_done the following cycle.
  - load_last without load_valid has no effect.
  - load_start while already in LOAD is ignored.
  - More than DEPTH words overwrite earlier words (wrap); this is not flagged.
- Read/write ordering: a fetch accepted in the first IDLE cycle after LOAD sees all loaded words. No read-during-write case exists, because fetch and load are never both accepted in LOAD.
- Memory array has no reset; only the CLEAR sweep initialises it. It is synthesizable as single-port RAM with a registered read.

Decomposition:
- Shared package mips_pkg holds:
  - typedef instr_t (logic [31:0]);
  - constant NOP_INSTR = 32'h0;
  - state enum imem_state_e {CLEAR, IDLE, LOAD}.
- Sub-module imem_array: DEPTH x DATA_W storage with one write port and one registered read port, no reset. The controller FSM, address decode and fault logic stay in instr_mem_ctrl.

Test Plan:
- Reset then wait:
  - busy=1 for exactly 32 cycles.
  - Then fetch_ready=1.
  - Fetch addr 0x7C -> fetch_valid next cycle, instr=0x00000000, no faults.
- Load 3 words from base 0:
  - Words 0x20080014, 0x2009000F, 0x0128802A, last word with load_last=1.
  - load_done pulses once, then state is IDLE.
  - Fetches 0x0/0x4/0x8 on consecutive cycles -> those three words on consecutive cycles.
- Fault cases:
  - Fetch 0x6 -> fetch_misalign=1, instr=NOP.
  - Fetch 0x80 -> fetch_oor=1.
  - Fetch 0x82 -> both flags=1.
- Wrap: load from base 30 with words A, B, C (C last) -> mem[30]=A, mem[31]=B, mem[0]=C, all verified by fetch.
- Simultaneous start: load_start and fetch_req(0x0) in the same IDLE cycle -> fetch returns the old mem[0] and LOAD is entered. A new word loaded at index 0 is visible on a fetch after load_done.
- Async reset mid-load: assert rst_n=0 after 2 of 4 load beats -> outputs 0 immediately. After release, a 32-cycle clear runs, and a fetch of 0x0 returns NOP.
